// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM state
// encoding, load/store size codes and the memory-mapped IO region tag.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // address[17:16] value that selects the UART/IO window
   localparam logic [1:0] IO_REGION = 2'b11;

   // Index of the final byte of a data transaction; size 3 behaves as a word.
   function automatic logic [1:0] last_index(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 2'd0;
         SIZE_HALF: return 2'd1;
         SIZE_WORD: return 2'd3;
         default:   return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the requesters (fetch / load-store), the byte-wide RAM
// port and the memory controller. master = requester/RAM side, slave = controller.
interface mem_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [7:0]            mem_din;
   logic [7:0]            mem_dout;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic                  mem_wr;
   logic                  io_buffer_full;

   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_done;
   logic [31:0]           if_rdata;

   logic                  d_req;
   logic                  d_wr;
   logic [1:0]            d_size;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [31:0]           d_wdata;
   logic                  d_done;
   logic [31:0]           d_rdata;

   logic                  flush_in;

   modport master (
      output mem_din, io_buffer_full,
      output if_req, if_addr,
      output d_req, d_wr, d_size, d_addr, d_wdata,
      output flush_in,
      input  mem_dout, mem_a, mem_wr,
      input  if_done, if_rdata,
      input  d_done, d_rdata
   );

   modport slave (
      input  mem_din, io_buffer_full,
      input  if_req, if_addr,
      input  d_req, d_wr, d_size, d_addr, d_wdata,
      input  flush_in,
      output mem_dout, mem_a, mem_wr,
      output if_done, if_rdata,
      output d_done, d_rdata
   );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves one instruction fetch (4 bytes) or one
// load/store (1/2/4 bytes) at a time over a byte-wide RAM with one cycle of
// read latency. Data requests win over fetches; fetches can be flushed.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rdy_in,
   mem_ctrl_if.slave  bus
);

   state_t                state_q, state_nxt;
   logic [1:0]            idx_q, idx_nxt;

   logic                  fetch_q;
   logic                  wr_q;
   logic [1:0]            last_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rbuf_q;
   logic [ADDR_WIDTH-1:0] a_hold_q;

   logic                  cap_vld_p1;
   logic [1:0]            cap_idx_p1;

   logic                  accept_d, accept_f;
   logic [ADDR_WIDTH-1:0] cur_a;
   logic                  io_stall;
   logic                  flush_hit;

   logic [ADDR_WIDTH-1:0] mem_a_c;
   logic                  mem_wr_c;
   logic [7:0]            mem_dout_c;
   logic                  if_done_c, d_done_c;
   logic [31:0]           if_rdata_c, d_rdata_c;

   assign accept_d  = (state_q == ST_IDLE) && bus.d_req;
   assign accept_f  = (state_q == ST_IDLE) && !bus.d_req && bus.if_req && !bus.flush_in;
   assign cur_a     = base_q + ADDR_WIDTH'(idx_q);
   assign io_stall  = wr_q && (cur_a[17:16] == IO_REGION) && bus.io_buffer_full;
   assign flush_hit = fetch_q && bus.flush_in && (state_q != ST_IDLE);

   // State register: reset wins over the rdy_in freeze.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
      end else if (rdy_in) begin
         state_q <= state_nxt;
         idx_q   <= idx_nxt;
      end
   end

   // Next state and byte index; a stalled IO write keeps the index in place.
   always_comb begin
      state_nxt = state_q;
      idx_nxt   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_d || accept_f) begin
               state_nxt = ST_ISSUE;
               idx_nxt   = 2'd0;
            end
         end
         ST_ISSUE: begin
            if (flush_hit) begin
               state_nxt = ST_IDLE;
               idx_nxt   = 2'd0;
            end else if (!io_stall) begin
               if (idx_q == last_q) begin
                  state_nxt = wr_q ? ST_DONE : ST_DRAIN;
                  idx_nxt   = 2'd0;
               end else begin
                  idx_nxt = idx_q + 2'd1;
               end
            end
         end
         ST_DRAIN: state_nxt = flush_hit ? ST_IDLE : ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Bus outputs; while frozen the last driven address is repeated so the RAM
   // presents that byte again once rdy_in returns.
   always_comb begin
      mem_a_c    = '0;
      mem_wr_c   = 1'b0;
      mem_dout_c = 8'd0;
      if_done_c  = 1'b0;
      if_rdata_c = '0;
      d_done_c   = 1'b0;
      d_rdata_c  = '0;
      case (state_q)
         ST_ISSUE: begin
            mem_a_c = rdy_in ? cur_a : a_hold_q;
            if (wr_q && rdy_in && !io_stall) begin
               mem_wr_c   = 1'b1;
               mem_dout_c = wdata_q[{idx_q, 3'b000} +: 8];
            end
         end
         ST_DRAIN: mem_a_c = a_hold_q;
         ST_DONE: begin
            if (fetch_q) begin
               if_done_c  = rdy_in && !bus.flush_in;
               if_rdata_c = rbuf_q;
            end else begin
               d_done_c  = rdy_in;
               d_rdata_c = rbuf_q;
            end
         end
         default: ;
      endcase
   end

   assign bus.mem_a    = mem_a_c;
   assign bus.mem_wr   = mem_wr_c;
   assign bus.mem_dout = mem_dout_c;
   assign bus.if_done  = if_done_c;
   assign bus.if_rdata = if_rdata_c;
   assign bus.d_done   = d_done_c;
   assign bus.d_rdata  = d_rdata_c;

   // Read-capture valid: a read address issued this cycle returns data next cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cap_vld_p1 <= 1'b0;
      end else if (rdy_in) begin
         cap_vld_p1 <= (state_q == ST_ISSUE) && !wr_q && !flush_hit;
      end
   end

   // Request latch, address hold and read-byte assembly (little-endian).
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         a_hold_q   <= mem_a_c;
         cap_idx_p1 <= idx_q;
         if (accept_d) begin
            base_q  <= bus.d_addr;
            wr_q    <= bus.d_wr;
            fetch_q <= 1'b0;
            last_q  <= last_index(bus.d_size);
            wdata_q <= bus.d_wdata;
            rbuf_q  <= '0;
         end else if (accept_f) begin
            base_q  <= bus.if_addr;
            wr_q    <= 1'b0;
            fetch_q <= 1'b1;
            last_q  <= 2'd3;
            rbuf_q  <= '0;
         end
         if (cap_vld_p1) begin
            rbuf_q[{cap_idx_p1, 3'b000} +: 8] <= bus.mem_din;
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM with one cycle read latency, directed
// scenarios plus randomized loads/stores/fetches compared against a
// transaction-level model (shadow memory + latency formula).
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   localparam int AW = 32;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;

   mem_ctrl_if #(.ADDR_WIDTH(AW)) bus();

   mem_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   logic [7:0] ram     [0:4095];
   logic [7:0] ref_mem [0:4095];
   logic [7:0] din_q;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // advance one clock; the RAM presents the byte addressed last cycle
   task automatic tick();
      @(posedge clk_in);
      #1;
      bus.mem_din = din_q;
   endtask

   // after inputs are set: let outputs settle and let the RAM act on them
   task automatic settle();
      #1;
      if (bus.mem_wr) ram[bus.mem_a[11:0]] = bus.mem_dout;
      din_q = ram[bus.mem_a[11:0]];
   endtask

   task automatic idle_inputs();
      bus.if_req         = 1'b0;
      bus.if_addr        = '0;
      bus.d_req          = 1'b0;
      bus.d_wr           = 1'b0;
      bus.d_size         = 2'd0;
      bus.d_addr         = '0;
      bus.d_wdata        = '0;
      bus.flush_in       = 1'b0;
      bus.io_buffer_full = 1'b0;
   endtask

   task automatic run_txn(input string tag, input bit fetch, input bit wr,
                          input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int frz_at,
                          input int frz_len, input int stall_len,
                          output logic [31:0] rd);
      int n, lat, done_k, nwr, wrong;
      bit st;
      logic [31:0] exp_rd;
      st  = wr && !fetch;
      n   = fetch ? 4 : (size == SIZE_BYTE) ? 1 : (size == SIZE_HALF) ? 2 : 4;
      lat = n + (st ? 1 : 2) + frz_len + ((st && addr[17:16] == 2'b11) ? stall_len : 0);
      exp_rd = '0;
      if (!st) for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_mem[12'(addr + i)];
      done_k = -1; nwr = 0; wrong = 0; rd = '0;
      tick();
      if (fetch) begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end else begin
         bus.d_req = 1'b1; bus.d_wr = wr; bus.d_size = size;
         bus.d_addr = addr; bus.d_wdata = wdata;
      end
      rdy_in = 1'b1;
      settle();
      for (int k = 1; k <= 64 && done_k < 0; k++) begin
         tick();
         rdy_in = !(k >= frz_at && k < frz_at + frz_len);
         bus.io_buffer_full = (k <= stall_len);
         settle();
         if (bus.mem_wr) begin
            if (nwr < n) begin
               check({tag, " wr_addr"}, bus.mem_a, addr + nwr);
               check({tag, " wr_data"}, bus.mem_dout, wdata[8*nwr +: 8]);
            end
            if (bus.io_buffer_full && bus.mem_a[17:16] == 2'b11)
               check({tag, " io_stall_wr"}, bus.mem_wr, 1'b0);
            nwr++;
         end
         if (fetch ? bus.if_done : bus.d_done) begin
            done_k = k;
            rd = fetch ? bus.if_rdata : bus.d_rdata;
         end
         if (fetch ? bus.d_done : bus.if_done) wrong++;
      end
      check({tag, " latency"}, done_k, lat);
      if (!st) check({tag, " rdata"}, rd, exp_rd);
      check({tag, " wr_count"}, nwr, st ? n : 0);
      check({tag, " other_done"}, wrong, 0);
      if (st) for (int i = 0; i < n; i++) ref_mem[12'(addr + i)] = wdata[8*i +: 8];
      tick();
      idle_inputs();
      rdy_in = 1'b1;
      settle();
      check({tag, " idle_bus"}, {bus.mem_wr, bus.mem_a}, 33'd0);
   endtask

   initial begin
      logic [31:0] rd, drd, frd, a, w;
      int dk, fk, cnt, n, base, fa, fl, sl;
      bit ft, wr, io;
      logic [1:0] sz;

      for (int i = 0; i < 4096; i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      din_q = 8'd0;
      bus.mem_din = 8'd0;
      idle_inputs();

      // reset while frozen and with a request pending: reset must win
      rst_in = 1'b1; rdy_in = 1'b0;
      bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'h55;
      for (int i = 0; i < 3; i++) begin tick(); settle(); end
      check("rst mem_a", bus.mem_a, 0);
      check("rst mem_dout", bus.mem_dout, 0);
      check("rst mem_wr", bus.mem_wr, 0);
      check("rst if_done", bus.if_done, 0);
      check("rst if_rdata", bus.if_rdata, 0);
      check("rst d_done", bus.d_done, 0);
      check("rst d_rdata", bus.d_rdata, 0);
      tick(); rst_in = 1'b0; rdy_in = 1'b1; idle_inputs(); settle();

      // fetch of a known instruction word
      ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
      for (int i = 0; i < 4; i++) ref_mem[12'h100 + i] = ram[12'h100 + i];
      run_txn("fetch100", 1'b1, 1'b0, 2'd0, 32'h100, 32'h0, 0, 0, 0, rd);
      check("fetch100 word", rd, 32'h0000_0513);

      // store half then read it back
      run_txn("sh200", 1'b0, 1'b1, SIZE_HALF, 32'h200, 32'hAABB_CCDD, 0, 0, 0, rd);
      run_txn("lh200", 1'b0, 1'b0, SIZE_HALF, 32'h200, 32'h0, 0, 0, 0, rd);
      check("lh200 value", rd, 32'h0000_CCDD);

      // collision: both requests rise together, data goes first
      tick();
      bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = SIZE_WORD; bus.d_addr = 32'h300;
      bus.if_req = 1'b1; bus.if_addr = 32'h104;
      settle();
      dk = -1; fk = -1; cnt = 0; drd = '0; frd = '0;
      for (int k = 1; k <= 40 && fk < 0; k++) begin
         tick();
         if (dk >= 0 && k == dk + 1) bus.d_req = 1'b0;
         settle();
         if (bus.d_done && dk < 0) begin dk = k; drd = bus.d_rdata; end
         if (bus.if_done) begin fk = k; frd = bus.if_rdata; end
         if (dk >= 0 && k == dk + 2) check("coll fetch_addr", bus.mem_a, 32'h104);
         if (bus.if_done && dk < 0) cnt++;
      end
      check("coll d_latency", dk, 6);
      check("coll f_latency", fk, 13);
      check("coll early_if_done", cnt, 0);
      check("coll d_rdata", drd, {ref_mem[12'h303], ref_mem[12'h302], ref_mem[12'h301], ref_mem[12'h300]});
      check("coll if_rdata", frd, {ref_mem[12'h107], ref_mem[12'h106], ref_mem[12'h105], ref_mem[12'h104]});
      tick(); idle_inputs(); settle();

      // IO write held off by a full UART buffer
      run_txn("io_sb", 1'b0, 1'b1, SIZE_BYTE, 32'h30000, 32'h41, 0, 0, 3, rd);

      // flush a fetch at byte index 2, then a fresh fetch completes
      tick(); bus.if_req = 1'b1; bus.if_addr = 32'h180; settle();
      tick(); settle();
      tick(); settle();
      tick(); bus.flush_in = 1'b1; bus.if_req = 1'b0; settle();
      check("flush issue_addr", bus.mem_a, 32'h182);
      cnt = bus.if_done ? 1 : 0;
      tick(); bus.flush_in = 1'b0; settle();
      check("flush idle_addr", bus.mem_a, 0);
      for (int k = 0; k < 8; k++) begin
         tick(); settle();
         if (bus.if_done) cnt++;
      end
      check("flush no_done", cnt, 0);
      run_txn("fetch104", 1'b1, 1'b0, 2'd0, 32'h104, 32'h0, 0, 0, 0, rd);

      // freeze two cycles in the middle of a word load
      run_txn("lw_frz", 1'b0, 1'b0, SIZE_WORD, 32'h200, 32'h0, 3, 2, 0, rd);

      // size code 3 behaves as a word
      run_txn("lsz3", 1'b0, 1'b0, 2'd3, 32'h240, 32'h0, 0, 0, 0, rd);

      // reset in the middle of a fetch drops it silently
      tick(); bus.if_req = 1'b1; bus.if_addr = 32'h120; settle();
      tick(); settle();
      tick(); settle();
      tick(); rst_in = 1'b1; rdy_in = 1'b0; bus.if_req = 1'b0; settle();
      tick(); rst_in = 1'b0; rdy_in = 1'b1; settle();
      check("midrst idle_addr", bus.mem_a, 0);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick(); settle();
         if (bus.if_done || bus.d_done) cnt++;
      end
      check("midrst no_done", cnt, 0);

      // randomized mix of fetches, loads and stores
      for (int t = 0; t < 80; t++) begin
         ft = ($urandom_range(0, 3) == 0);
         wr = !ft && $urandom_range(0, 1) == 1;
         sz = 2'($urandom_range(0, 3));
         io = wr && ($urandom_range(0, 4) == 0);
         a  = io ? 32'h30000 + $urandom_range(0, 15) : 32'($urandom_range(0, 12'hFF0));
         w  = $urandom;
         n  = ft ? 4 : (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALF) ? 2 : 4;
         base = n + (wr ? 1 : 2);
         fa = 0; fl = 0; sl = 0;
         if (io) sl = $urandom_range(0, 3);
         else if ($urandom_range(0, 2) == 0) begin
            fa = $urandom_range(1, base);
            fl = $urandom_range(1, 3);
         end
         run_txn($sformatf("rnd%0d", t), ft, wr, sz, a, w, fa, fl, sl, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 SHALL have ports clk_in input 1, the single clock; rst_in input 1, reset, synchronous and active-high.
REQ-003 SHALL have port rdy_in input 1; low freezes all state.
REQ-004 SHALL have ports mem_din input 8 (RAM read byte) and mem_dout output 8 (RAM write byte).
REQ-005 SHALL have ports mem_a output ADDR_WIDTH (byte address) and mem_wr output 1 (1 = write).
REQ-006 SHALL have port io_buffer_full input 1; UART buffer is full.
REQ-007 SHALL have ports if_req input 1, if_addr input ADDR_WIDTH; fetch request for 4 bytes.
REQ-008 SHALL have ports if_done output 1, if_rdata output 32; fetch result.
REQ-009 SHALL have ports d_req input 1, d_wr input 1, d_size input 2 (0 = byte, 1 = half, 2 = word), d_addr input ADDR_WIDTH, d_wdata input 32; load/store request.
REQ-010 SHALL have ports d_done output 1, d_rdata output 32; load/store result.
REQ-011 SHALL have port flush_in input 1; aborts any fetch.

Function
REQ-012 Requester SHALL hold req and all fields stable until its done pulse; controller SHALL serve one transaction at a time.
REQ-013 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-014 Transaction length N SHALL be 4 for fetch; 1, 2 or 4 from d_size for data. d_size = 3 SHALL be treated as 4.
REQ-015 In IDLE, with d_req high, SHALL latch the data request; otherwise, with if_req high and flush_in low, SHALL latch the fetch. Next state: ISSUE, byte index 0.
REQ-016 ISSUE SHALL drive mem_a = base + index, one byte per cycle. Index 0 is driven in the cycle after acceptance.
REQ-017 For writes, ISSUE SHALL drive mem_wr = 1 and mem_dout = wdata byte[index], little-endian.
REQ-018 For reads, ISSUE SHALL drive mem_wr = 0 and capture mem_din one cycle after each address into rdata byte[index-1].
REQ-019 After the last read address, state SHALL go to DRAIN to capture the final byte, then to DONE.
REQ-020 After the last write byte, state SHALL go directly to DONE.
REQ-021 Latency from the accepting cycle C: read done high in cycle C+N+2; write done high in cycle C+N+1.
REQ-022 DONE SHALL pulse exactly one of if_done/d_done for one cycle, with rdata valid that cycle; unused upper rdata bytes SHALL be zero. Next state: IDLE.
REQ-023 A write byte with address[17:16] == 2'b11 while io_buffer_full = 1 SHALL stall: mem_wr = 0, index held, until full drops.
REQ-024 flush_in high during a fetch in ISSUE/DRAIN/DONE SHALL force IDLE next cycle, suppress if_done and discard the in-flight byte.
REQ-025 flush_in SHALL NOT affect data transactions.
REQ-026 Arbitration SHALL be non-preemptive; a data request arriving mid-fetch waits for IDLE.
REQ-027 When both requests are pending in IDLE, data SHALL win.
REQ-028 In IDLE and DONE, SHALL drive mem_wr = 0 and mem_a = 0.
REQ-029 rdy_in low SHALL freeze state, index and captured data, force mem_wr = 0 and hold mem_a.
REQ-030 A byte read whose address was driven in the cycle before the freeze SHALL be recaptured; the address SHALL be re-driven after rdy_in returns.

Reset
REQ-031 rst_in SHALL take priority over rdy_in.
REQ-032 On rst_in, state SHALL go to IDLE and index to 0.
REQ-033 On rst_in, all outputs SHALL be 0: mem_a, mem_dout, mem_wr, if_done, if_rdata, d_done, d_rdata.
REQ-034 Reset mid-transaction SHALL drop the transaction with no done pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the d_size encodings and the IO region constant 2'b11.
REQ-036 Single module; no sub-module is needed.

Verification
REQ-037 Fetch: if_addr = 0x100, RAM holds 0x13,0x05,0x00,0x00 -> if_done in cycle C+6 with if_rdata = 0x00000513.
REQ-038 Store half: d_addr = 0x200, d_wdata = 0xAABBCCDD -> mem_wr = 1 at 0x200 with 0xDD, then 0x201 with 0xCC; d_done at C+3.
REQ-039 Collision: if_req and d_req rise together -> data served first; fetch accepted in the cycle after d_done.
REQ-040 IO stall: byte write 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr = 0 for those cycles, then one write; d_done follows.
REQ-041 Flush: flush_in pulsed at index 2 of a fetch -> no if_done; IDLE next cycle; a fresh fetch to 0x104 completes normally.
REQ-042 Freeze: rdy_in low for 2 cycles mid-load word -> d_rdata is correct and latency grows by exactly 2.
